// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   - Bus widths for instruction address/data and the byte-wide memory port.
//   - IF FSM state encoding, fetch byte count and the counter width.
//   - if_id_t: the {pc, inst} payload handed to the if_id register.
package stage_if_pkg;

  localparam int unsigned INST_ADDR_W = 32;  // InstAddrBus
  localparam int unsigned INST_W      = 32;  // InstBus
  localparam int unsigned MEM_ADDR_W  = 32;  // memory request address width
  localparam int unsigned MEM_DATA_W  = 8;   // memory request data width
  localparam int unsigned FETCH_BYTES = 4;
  localparam int unsigned CNT_W       = 3;   // must be able to hold FETCH_BYTES

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;
  typedef logic [MEM_ADDR_W-1:0]  mem_addr_t;
  typedef logic [MEM_DATA_W-1:0]  mem_data_t;
  typedef logic [CNT_W-1:0]       byte_cnt_t;

  localparam byte_cnt_t BYTES_DONE = CNT_W'(FETCH_BYTES);
  localparam byte_cnt_t LAST_LANE  = CNT_W'(FETCH_BYTES - 1);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,  // bytes still outstanding
    S_FULL  = 1'b1   // word complete, waiting for the output register
  } if_state_e;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } if_id_t;

  // Replace byte lane `lane` of `w` with `b` (little-endian lanes).
  function automatic inst_t insert_byte(input inst_t w, input byte_cnt_t lane,
                                        input mem_data_t b);
    inst_t r;
    r = w;
    for (int unsigned k = 0; k < FETCH_BYTES; k++) begin
      if (lane == CNT_W'(k)) r[k*MEM_DATA_W +: MEM_DATA_W] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/if_byte_assembler.sv
// Collects the four returning instruction bytes into one little-endian word.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   gnt           a byte request was granted this cycle (data returns next cycle)
//   flush         redirect accepted: discard partial word, drop the byte granted now
//   clear         completed word taken by the output register; restart at lane 0
//   data          returning memory byte
//   complete_c    word complete this cycle (includes a final byte arriving now)
//   word_c        assembled word including any byte arriving this cycle
module if_byte_assembler
  import stage_if_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gnt,
  input  logic                  flush,
  input  logic                  clear,
  input  logic [MEM_DATA_W-1:0] data,
  output logic                  complete_c,
  output logic [INST_W-1:0]     word_c
);

  logic      pend;      // a granted byte lands on data this cycle
  logic      drop;      // that byte belongs to a flushed fetch
  byte_cnt_t rcv;
  inst_t     asm_word;
  logic      capture_c;

  assign capture_c = pend & ~drop;

  // Completing in the same cycle as the last byte saves a cycle of latency.
  assign complete_c = (rcv == BYTES_DONE) | ((rcv == LAST_LANE) & capture_c);

  always_comb begin
    word_c = asm_word;
    if (capture_c) word_c = insert_byte(asm_word, rcv, data);
  end

  // Receive counter, lane writes and drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= 1'b0;
      drop     <= 1'b0;
      rcv      <= '0;
      asm_word <= '0;
    end else begin
      pend <= gnt;
      drop <= flush & gnt;
      if (flush || clear) begin
        rcv      <= '0;
        asm_word <= '0;
      end else if (capture_c) begin
        rcv      <= rcv + CNT_W'(1);
        asm_word <= word_c;
      end
    end
  end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: holds the PC, fetches each instruction as four byte
// reads over the shared memory port and presents {pc, inst, valid} to if_id.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 run enable; 0 freezes the stage (returning bytes still land)
//   mem_req_o/addr_o    byte-read request and its address
//   mem_grant_i         arbiter accepted the request this cycle
//   mem_data_i          read byte, one cycle after the grant
//   stall_i             downstream cannot take the output this cycle
//   branch_enable_i     redirect pulse from decode, target branch_addr_i
//   pc_o, inst_o        presented instruction and its address
//   valid_o             pc_o/inst_o hold a live instruction
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  output logic                   mem_req_o,
  output logic [MEM_ADDR_W-1:0]  mem_addr_o,
  input  logic                   mem_grant_i,
  input  logic [MEM_DATA_W-1:0]  mem_data_i,
  input  logic                   stall_i,
  input  logic                   branch_enable_i,
  input  logic [INST_ADDR_W-1:0] branch_addr_i,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0]      inst_o,
  output logic                   valid_o
);

  if_state_e  state, state_nxt;
  inst_addr_t fetch_pc, fetch_pc_nxt;
  byte_cnt_t  iss, iss_nxt;
  if_id_t     out_q, out_nxt;
  logic       valid_q, valid_nxt;

  logic       redirect_c;
  logic       transfer_c;
  logic       req_c;
  logic       gnt_c;
  logic       complete_c;
  inst_t      word_c;
  inst_addr_t req_pc_c;
  byte_cnt_t  req_iss_c;

  if_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .gnt        (gnt_c),
    .flush      (redirect_c),
    .clear      (transfer_c),
    .data       (mem_data_i),
    .complete_c (complete_c),
    .word_c     (word_c)
  );

  assign redirect_c = rdy & branch_enable_i;
  assign transfer_c = rdy & ~branch_enable_i & complete_c & (~valid_q | ~stall_i);

  // On a transfer the next word's first byte is requested in the same cycle.
  always_comb begin
    req_pc_c  = fetch_pc;
    req_iss_c = iss;
    if (transfer_c) begin
      req_pc_c  = fetch_pc + INST_ADDR_W'(FETCH_BYTES);
      req_iss_c = '0;
    end
  end

  // Request port; the request stays up during a redirect so a grant there is dropped.
  always_comb begin
    req_c      = ~rst & rdy & (transfer_c | ((state == S_FETCH) & (iss < BYTES_DONE)));
    gnt_c      = req_c & mem_grant_i;
    mem_req_o  = req_c;
    mem_addr_o = '0;
    if (!rst) mem_addr_o = req_pc_c + INST_ADDR_W'(req_iss_c);
  end

  // Next-state: redirect, freeze, transfer/issue/consume in priority order.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    iss_nxt      = iss;
    out_nxt      = out_q;
    valid_nxt    = valid_q;

    if (redirect_c) begin
      state_nxt    = S_FETCH;
      fetch_pc_nxt = branch_addr_i;
      iss_nxt      = '0;
      valid_nxt    = 1'b0;
    end else if (rdy) begin
      if (transfer_c) begin
        state_nxt    = S_FETCH;
        fetch_pc_nxt = req_pc_c;
        iss_nxt      = gnt_c ? CNT_W'(1) : '0;
        out_nxt.pc   = fetch_pc;
        out_nxt.inst = word_c;
        valid_nxt    = 1'b1;
      end else begin
        if (complete_c) state_nxt = S_FULL;
        if (gnt_c) iss_nxt = iss + CNT_W'(1);
        if (valid_q && !stall_i) valid_nxt = 1'b0;
      end
    end else if (complete_c) begin
      // A byte landing while frozen can still finish the word.
      state_nxt = S_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC;
      iss      <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      iss      <= iss_nxt;
      out_q    <= out_nxt;
      valid_q  <= valid_nxt;
    end
  end

  assign pc_o    = out_q.pc;
  assign inst_o  = out_q.inst;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_stage_if.sv
module tb_stage_if;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_grant_i;
  logic [7:0]  mem_data_i;
  logic        stall_i;
  logic        branch_enable_i;
  logic [31:0] branch_addr_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stage_if #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_grant_i     (mem_grant_i),
    .mem_data_i      (mem_data_i),
    .stall_i         (stall_i),
    .branch_enable_i (branch_enable_i),
    .branch_addr_i   (branch_addr_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .valid_o         (valid_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic        s_req, s_grant, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;
  logic        gnt_hit;
  logic [31:0] gaddr;

  // Memory image: first word is addi a0,x0,10; elsewhere an address hash.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    case (a)
      32'h0:   return 8'h13;
      32'h1:   return 8'h05;
      32'h2:   return 8'hA0;
      32'h3:   return 8'h00;
      default: return 8'(lo * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h6B;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] p);
    return {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
  endfunction

  // One clock: sample at negedge, score consumed outputs, return the granted byte.
  task automatic step();
    exp_t e;
    @(negedge clk);
    s_req   = mem_req_o;
    s_addr  = mem_addr_o;
    s_grant = mem_grant_i;
    s_valid = valid_o;
    s_pc    = pc_o;
    s_inst  = inst_o;
    gnt_hit = mem_req_o & mem_grant_i;
    gaddr   = mem_addr_o;
    if (!rst && valid_o && !stall_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, required no output", pc_o, inst_o);
      end else begin
        e = sb.pop_front();
        if (pc_o !== e.pc || inst_o !== e.inst) begin
          bad++;
          $display("FAIL sb_word: got pc=%h inst=%h, required pc=%h inst=%h",
                   pc_o, inst_o, e.pc, e.inst);
        end
      end
    end
    @(posedge clk);
    #1;
    mem_data_i = gnt_hit ? mem_byte(gaddr) : 8'hEE;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; mem_grant_i = 1'b0; stall_i = 1'b0;
    branch_enable_i = 1'b0; branch_addr_i = 32'h0;
    step();
    step();
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d words pending, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; mem_grant_i = 1'b1; stall_i = 1'b0;
    branch_enable_i = 1'b0; branch_addr_i = 32'h0;
    step();
    step();
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b, required 0", s_req); end
    total++; if (s_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h, required 0", s_addr); end
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", s_valid); end
    total++; if (s_inst !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h, required 0", s_inst); end
    total++; if (s_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h, required 0", s_pc); end
    mem_grant_i = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    mem_grant_i = 1'b1;
    sb.push_back('{pc: 32'h0, inst: 32'h00A00513});
    sb.push_back('{pc: 32'h4, inst: word_at(32'h4)});
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (s_req !== 1'b1 || s_addr !== 32'(c)) begin
        bad++;
        $display("FAIL basic_addr%0d: got req=%b addr=%h, required req=1 addr=%h", c, s_req, s_addr, 32'(c));
      end
    end
    step();
    total++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_inst !== 32'h00A00513) begin
      bad++;
      $display("FAIL basic_first: got valid=%b pc=%h inst=%h, required valid=1 pc=0 inst=00a00513",
               s_valid, s_pc, s_inst);
    end
    drain("basic", 20);
  endtask

  task automatic test_grant_toggle();
    logic        p_req, p_grant;
    logic [31:0] p_addr;
    do_reset();
    sb.push_back('{pc: 32'h0, inst: 32'h00A00513});
    sb.push_back('{pc: 32'h4, inst: word_at(32'h4)});
    sb.push_back('{pc: 32'h8, inst: word_at(32'h8)});
    p_req = 1'b0; p_grant = 1'b0; p_addr = 32'h0;
    for (int c = 0; c < 80 && sb.size() != 0; c++) begin
      mem_grant_i = (c % 2 == 0);
      step();
      if (p_req && !p_grant) begin
        total++;
        if (s_req !== 1'b1 || s_addr !== p_addr) begin
          bad++;
          $display("FAIL toggle_hold: got req=%b addr=%h, required req=1 addr=%h", s_req, s_addr, p_addr);
        end
      end
      p_req = s_req; p_grant = s_grant; p_addr = s_addr;
    end
    drain("toggle", 1);
  endtask

  task automatic test_stall();
    logic [31:0] w0;
    w0 = 32'h00A00513;
    do_reset();
    mem_grant_i = 1'b1;
    stall_i = 1'b1;
    sb.push_back('{pc: 32'h0, inst: w0});
    sb.push_back('{pc: 32'h4, inst: word_at(32'h4)});
    for (int c = 0; c < 5; c++) step();
    for (int c = 5; c < 15; c++) begin
      step();
      total++;
      if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_inst !== w0) begin
        bad++;
        $display("FAIL stall_hold%0d: got valid=%b pc=%h inst=%h, required valid=1 pc=0 inst=%h",
                 c, s_valid, s_pc, s_inst, w0);
      end
    end
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL stall_full_req: got %b, required 0", s_req); end
    stall_i = 1'b0;
    step();
    total++;
    if (s_req !== 1'b1 || s_addr !== 32'h8) begin
      bad++;
      $display("FAIL stall_prefetch: got req=%b addr=%h, required req=1 addr=8", s_req, s_addr);
    end
    step();
    total++;
    if (s_valid !== 1'b1 || s_pc !== 32'h4) begin
      bad++;
      $display("FAIL stall_nobubble: got valid=%b pc=%h, required valid=1 pc=4", s_valid, s_pc);
    end
    drain("stall", 5);
  endtask

  task automatic test_branch();
    do_reset();
    mem_grant_i = 1'b1;
    sb.push_back('{pc: 32'h1000, inst: word_at(32'h1000)});
    step();
    step();
    branch_enable_i = 1'b1;
    branch_addr_i = 32'h1000;
    step();
    total++;
    if (s_req !== 1'b1 || s_addr !== 32'h2) begin
      bad++;
      $display("FAIL branch_inflight: got req=%b addr=%h, required req=1 addr=2", s_req, s_addr);
    end
    branch_enable_i = 1'b0;
    step();
    total++;
    if (s_req !== 1'b1 || s_addr !== 32'h1000 || s_valid !== 1'b0) begin
      bad++;
      $display("FAIL branch_restart: got req=%b addr=%h valid=%b, required req=1 addr=1000 valid=0",
               s_req, s_addr, s_valid);
    end
    drain("branch", 20);
  endtask

  task automatic test_branch_consume_complete();
    do_reset();
    mem_grant_i = 1'b1;
    stall_i = 1'b1;
    sb.push_back('{pc: 32'h0, inst: 32'h00A00513});
    sb.push_back('{pc: 32'h2000, inst: word_at(32'h2000)});
    for (int c = 0; c < 8; c++) step();
    stall_i = 1'b0;
    branch_enable_i = 1'b1;
    branch_addr_i = 32'h2000;
    step();
    branch_enable_i = 1'b0;
    step();
    total++;
    if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h2000) begin
      bad++;
      $display("FAIL bcc_flush: got valid=%b req=%b addr=%h, required valid=0 req=1 addr=2000",
               s_valid, s_req, s_addr);
    end
    drain("bcc", 20);
  endtask

  task automatic test_rdy_reset();
    do_reset();
    mem_grant_i = 1'b1;
    sb.push_back('{pc: 32'h0, inst: 32'h00A00513});
    step();
    step();
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (s_req !== 1'b0) begin bad++; $display("FAIL rdy_pause%0d: got req=%b, required 0", c, s_req); end
    end
    rdy = 1'b1;
    step();
    total++;
    if (s_req !== 1'b1 || s_addr !== 32'h2) begin
      bad++;
      $display("FAIL rdy_resume: got req=%b addr=%h, required req=1 addr=2", s_req, s_addr);
    end
    rst = 1'b1;
    step();
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL midreset_req: got %b, required 0", s_req); end
    rst = 1'b0;
    step();
    total++;
    if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_restart: got req=%b addr=%h valid=%b, required req=1 addr=0 valid=0",
               s_req, s_addr, s_valid);
    end
    drain("rdyrst", 20);
  endtask

  task automatic test_wrap();
    do_reset();
    mem_grant_i = 1'b1;
    branch_enable_i = 1'b1;
    branch_addr_i = 32'hFFFF_FFFC;
    sb.push_back('{pc: 32'hFFFF_FFFC, inst: word_at(32'hFFFF_FFFC)});
    sb.push_back('{pc: 32'h0, inst: 32'h00A00513});
    step();
    branch_enable_i = 1'b0;
    drain("wrap", 30);
  endtask

  initial begin
    mem_data_i = 8'h00;
    test_reset();
    test_basic();
    test_grant_toggle();
    test_stall();
    test_branch();
    test_branch_consume_complete();
    test_rdy_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
